rv32i_hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the RV32I IF/ID/EX(/MEM/WB) datapath. Tracks in-flight

---
 rtl/rv32i_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rv32i_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl
//   Hazard controller for an RV32I IF/ID/EX/MEM/WB pipe. It keeps a shadow copy of
//   the EX, MEM and WB destination registers and drives the pipe's control signals:
//   registered operand-forward selects, combinational stall enables and flushes.
//   When several hazards occur in the same cycle, data-memory wait beats a taken
//   branch, and a taken branch beats a load-use stall.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   RUN      | normal flow; branch flush and load-use stall are evaluated here
//   MEM_WAIT | data memory busy; whole pipe frozen until Mem_busy drops
//   BR_FLUSH | one cycle after a taken branch; EX holds a bubble, branch ignored
//
// Ports
//   Clk, Reset_n                          clock (rising edge), async active-low reset
//   ID_Rs1_addr/ID_Rs2_addr/ID_Rd_addr    register addresses of the ID instruction
//   ID_RegFile_wr_en, ID_Mem_rd_en        ID instruction writes rd / is a load
//   EX_PC_source_sel                      taken branch/jump resolved in EX
//   Mem_busy                              data memory not ready
//   IF_Stall, ID_Stall, EX_Stall          hold PC+IF/ID, ID/EX, EX/MEM
//   ID_Flush, EX_Flush                    squash IF/ID, ID/EX at next edge
//   ForwardA, ForwardB                    00 regfile, 10 EX/MEM, 01 MEM/WB
//   Stall_count                           saturating count of IF_Stall cycles
module rv32i_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [REG_AW-1:0] ID_Rs1_addr,
  input  logic [REG_AW-1:0] ID_Rs2_addr,
  input  logic [REG_AW-1:0] ID_Rd_addr,
  input  logic              ID_RegFile_wr_en,
  input  logic              ID_Mem_rd_en,
  input  logic              EX_PC_source_sel,
  input  logic              Mem_busy,
  output logic              IF_Stall,
  output logic              ID_Stall,
  output logic              EX_Stall,
  output logic              ID_Flush,
  output logic              EX_Flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic [CNT_W-1:0]  Stall_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, BR_FLUSH} state_t;

  state_t state, state_nxt;

  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              ex_wr, ex_mrd, mem_wr, wb_wr;

  logic              freeze, flush, lu_stall, load_use;
  logic [REG_AW-1:0] nx_rs1, nx_rs2, nx_rd;
  logic              nx_wr, nx_mrd;
  logic [1:0]        fwd_a_nxt, fwd_b_nxt;

  assign load_use = ex_mrd && (ex_rd != '0) &&
                    ((ex_rd == ID_Rs1_addr) || (ex_rd == ID_Rs2_addr));

  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    flush     = 1'b0;
    lu_stall  = 1'b0;
    case (state)
      // Once memory is ready, MEM_WAIT behaves exactly like RUN in that same cycle,
      // so a branch held in EX during the wait is serviced without an extra stall.
      RUN, MEM_WAIT: begin
        if (Mem_busy) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (EX_PC_source_sel) begin
          flush     = 1'b1;
          state_nxt = BR_FLUSH;
        end else begin
          lu_stall  = load_use;
          state_nxt = RUN;
        end
      end
      BR_FLUSH: begin
        if (Mem_busy) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted so the pipe sees no control
  // activity even if Mem_busy is still high.
  assign IF_Stall = Reset_n & (freeze | lu_stall);
  assign ID_Stall = Reset_n & (freeze | lu_stall);
  assign EX_Stall = Reset_n & freeze;
  assign ID_Flush = Reset_n & flush;
  assign EX_Flush = Reset_n & flush;

  // Incoming EX entry: bubble on flush or load-use stall.
  always_comb begin
    nx_rs1 = ID_Rs1_addr;
    nx_rs2 = ID_Rs2_addr;
    nx_rd  = ID_Rd_addr;
    nx_wr  = ID_RegFile_wr_en;
    nx_mrd = ID_Mem_rd_en;
    if (flush || lu_stall) begin
      nx_rs1 = '0;
      nx_rs2 = '0;
      nx_rd  = '0;
      nx_wr  = 1'b0;
      nx_mrd = 1'b0;
    end
  end

  // Next MEM entry is the current EX entry, next WB is the current MEM entry.
  // A bubble has rs=0, and rd!=0 is required, so it never forwards.
  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (ex_wr && (ex_rd != '0) && (ex_rd == nx_rs1))
      fwd_a_nxt = 2'b10;
    else if (mem_wr && (mem_rd != '0) && (mem_rd == nx_rs1))
      fwd_a_nxt = 2'b01;
    if (ex_wr && (ex_rd != '0) && (ex_rd == nx_rs2))
      fwd_b_nxt = 2'b10;
    else if (mem_wr && (mem_rd != '0) && (mem_rd == nx_rs2))
      fwd_b_nxt = 2'b01;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= RUN;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_wr       <= 1'b0;
      ex_mrd      <= 1'b0;
      mem_rd      <= '0;
      mem_wr      <= 1'b0;
      wb_rd       <= '0;
      wb_wr       <= 1'b0;
      ForwardA    <= 2'b00;
      ForwardB    <= 2'b00;
      Stall_count <= '0;
    end else begin
      state <= state_nxt;
      if (!freeze) begin
        wb_rd    <= mem_rd;
        wb_wr    <= mem_wr;
        mem_rd   <= ex_rd;
        mem_wr   <= ex_wr;
        ex_rs1   <= nx_rs1;
        ex_rs2   <= nx_rs2;
        ex_rd    <= nx_rd;
        ex_wr    <= nx_wr;
        ex_mrd   <= nx_mrd;
        ForwardA <= fwd_a_nxt;
        ForwardB <= fwd_b_nxt;
      end
      if (IF_Stall && (Stall_count != {CNT_W{1'b1}}))
        Stall_count <= Stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
module tb_rv32i_hazard_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic [4:0] ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr;
  logic       ID_RegFile_wr_en, ID_Mem_rd_en, EX_PC_source_sel, Mem_busy;

  logic        IF_Stall, ID_Stall, EX_Stall, ID_Flush, EX_Flush;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] Stall_count;

  logic        s_if_stall, s_id_stall, s_ex_stall, s_id_flush, s_ex_flush;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_count;

  int checks   = 0;
  int failures = 0;

  rv32i_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
    .ID_RegFile_wr_en(ID_RegFile_wr_en), .ID_Mem_rd_en(ID_Mem_rd_en),
    .EX_PC_source_sel(EX_PC_source_sel), .Mem_busy(Mem_busy),
    .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall),
    .ID_Flush(ID_Flush), .EX_Flush(EX_Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall_count(Stall_count)
  );

  rv32i_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
    .ID_RegFile_wr_en(ID_RegFile_wr_en), .ID_Mem_rd_en(ID_Mem_rd_en),
    .EX_PC_source_sel(EX_PC_source_sel), .Mem_busy(Mem_busy),
    .IF_Stall(s_if_stall), .ID_Stall(s_id_stall), .EX_Stall(s_ex_stall),
    .ID_Flush(s_id_flush), .EX_Flush(s_ex_flush),
    .ForwardA(s_fwd_a), .ForwardB(s_fwd_b), .Stall_count(s_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  wire [4:0] ctl = {IF_Stall, ID_Stall, EX_Stall, ID_Flush, EX_Flush};

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wr, input logic mrd);
    ID_Rs1_addr      = rs1;
    ID_Rs2_addr      = rs2;
    ID_Rd_addr       = rd;
    ID_RegFile_wr_en = wr;
    ID_Mem_rd_en     = mrd;
  endtask

  task automatic do_reset;
    Reset_n          = 1'b0;
    EX_PC_source_sel = 1'b0;
    Mem_busy         = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=00000", ctl);
    end
    checks++;
    if ({ForwardA, ForwardB} !== 4'b0000) begin
      failures++; $display("FAIL reset_fwd got=%b exp=0000", {ForwardA, ForwardB});
    end
    checks++;
    if (Stall_count !== 16'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", Stall_count);
    end
  endtask

  task automatic test_forward;
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0);   // sub x6, x5, x0
    tick();
    checks++;
    if ({ForwardA, ForwardB} !== 4'b1000) begin
      failures++; $display("FAIL fwd_mem got=%b exp=1000", {ForwardA, ForwardB});
    end
    set_id(5'd5, 5'd6, 5'd8, 1'b1, 1'b0);   // or x8, x5, x6
    tick();
    checks++;
    if ({ForwardA, ForwardB} !== 4'b0110) begin
      failures++; $display("FAIL fwd_wb_mem got=%b exp=0110", {ForwardA, ForwardB});
    end
    set_id(5'd0, 5'd0, 5'd8, 1'b1, 1'b0);   // add x8 again
    tick();
    set_id(5'd8, 5'd8, 5'd0, 1'b0, 1'b0);   // reads x8: MEM and WB both match
    tick();
    checks++;
    if ({ForwardA, ForwardB} !== 4'b1010) begin
      failures++; $display("FAIL fwd_priority got=%b exp=1010", {ForwardA, ForwardB});
    end
  endtask

  task automatic test_load_use;
    do_reset();
    set_id(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    set_id(5'd1, 5'd7, 5'd9, 1'b1, 1'b0);   // add x9, x1, x7
    #1;
    checks++;
    if (ctl !== 5'b11000) begin
      failures++; $display("FAIL lu_stall got=%b exp=11000", ctl);
    end
    tick();
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL lu_release got=%b exp=00000", ctl);
    end
    checks++;
    if ({ForwardA, ForwardB} !== 4'b0000) begin
      failures++; $display("FAIL lu_bubble_fwd got=%b exp=0000", {ForwardA, ForwardB});
    end
    checks++;
    if (Stall_count !== 16'd1) begin
      failures++; $display("FAIL lu_count got=%0d exp=1", Stall_count);
    end
    tick();
    // bubble sits between the load and its consumer, so data comes from MEM/WB
    checks++;
    if ({ForwardA, ForwardB} !== 4'b0001) begin
      failures++; $display("FAIL lu_fwd got=%b exp=0001", {ForwardA, ForwardB});
    end
  endtask

  task automatic test_x0;
    do_reset();
    set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);   // lw x0
    tick();
    set_id(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL x0_stall got=%b exp=00000", ctl);
    end
    tick();
    checks++;
    if ({ForwardA, ForwardB, Stall_count} !== 20'h0) begin
      failures++; $display("FAIL x0_fwd got=%b cnt=%0d exp=0000 cnt=0", {ForwardA, ForwardB}, Stall_count);
    end
  endtask

  task automatic test_branch;
    do_reset();
    set_id(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    set_id(5'd7, 5'd0, 5'd4, 1'b1, 1'b0);   // load-use also true
    EX_PC_source_sel = 1'b1;
    #1;
    checks++;
    if (ctl !== 5'b00011) begin
      failures++; $display("FAIL br_flush got=%b exp=00011", ctl);
    end
    tick();
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL br_ignored got=%b exp=00000", ctl);
    end
    checks++;
    if ({ForwardA, ForwardB, Stall_count} !== 20'h0) begin
      failures++; $display("FAIL br_fwd got=%b cnt=%0d exp=0000 cnt=0", {ForwardA, ForwardB}, Stall_count);
    end
    EX_PC_source_sel = 1'b0;
    tick();
  endtask

  task automatic test_mem_wait;
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0);   // sub reads x5
    tick();
    set_id(5'd0, 5'd0, 5'd2, 1'b1, 1'b0);   // advancing this would yield ForwardA=00
    EX_PC_source_sel = 1'b1;
    Mem_busy         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 5'b11100) begin
        failures++; $display("FAIL mw_freeze cyc=%0d got=%b exp=11100", i, ctl);
      end
      tick();
      checks++;
      if (ForwardA !== 2'b10) begin
        failures++; $display("FAIL mw_fwd_hold cyc=%0d got=%b exp=10", i, ForwardA);
      end
    end
    Mem_busy = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b00011) begin
      failures++; $display("FAIL mw_branch got=%b exp=00011", ctl);
    end
    checks++;
    if (Stall_count !== 16'd3) begin
      failures++; $display("FAIL mw_count got=%0d exp=3", Stall_count);
    end
    tick();
    EX_PC_source_sel = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    Mem_busy = 1'b1;
    repeat (5) tick();
    checks++;
    if (ctl !== 5'b11100) begin
      failures++; $display("FAIL rw_freeze got=%b exp=11100", ctl);
    end
    checks++;
    if (Stall_count !== 16'd5) begin
      failures++; $display("FAIL rw_count got=%0d exp=5", Stall_count);
    end
    checks++;
    if (s_count !== 2'd3) begin
      failures++; $display("FAIL sat_count got=%0d exp=3", s_count);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({ctl, ForwardA, ForwardB} !== 9'b0) begin
      failures++; $display("FAIL rw_outputs got=%b exp=000000000", {ctl, ForwardA, ForwardB});
    end
    checks++;
    if ({Stall_count, s_count} !== 18'd0) begin
      failures++; $display("FAIL rw_counts got=%0d/%0d exp=0/0", Stall_count, s_count);
    end
    Mem_busy = 1'b0;
    #2;
    Reset_n = 1'b1;
    tick();
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL rw_after got=%b exp=00000", ctl);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
